// File: rtl/count_game_pkg.sv
// Shared types and constants for the countdown game controller.
// No logic; state encoding, winner codes and score helpers only.
// Imported by the controller and its testbench-facing ports.
package count_game_pkg;

  localparam int SCORE_W = 4;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_RUN       = 3'd2,
    ST_SHOW      = 3'd3,
    ST_MATCH_END = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Score increment that sticks at the maximum instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle tick every TICK_DIV cycles; clr restarts the period.
// Latency: tick is high in the last cycle of each period (cycle TICK_DIV-1 after clear).
// Backpressure: none; free-running counter, clr has priority over counting.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..TICK_DIV-1, restarting on clear or at terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/count_game_ctrl.sv
// Round/match controller: sequences the countdown counter, arbitrates players, keeps score.
// Latency: every output is registered; a decision made in cycle t is visible in cycle t+1.
// Backpressure: none; buttons are single-cycle pulses and are dropped in states that ignore them.
module count_game_ctrl
  import count_game_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int ARM_TICKS  = 2,
  parameter int SHOW_TICKS = 3,
  parameter int INIT_NUM   = 5,
  parameter int MIN_NUM    = 1,
  parameter int WIN_SCORE  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               p1_btn,
  input  logic               p2_btn,
  input  logic [2:0]         cnt_val,
  output logic [2:0]         cnt_num,
  output logic               cnt_st,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic               round_done,
  output logic               match_over,
  output logic [2:0]         state
);

  localparam logic [2:0]         INIT_PRESET = 3'(INIT_NUM);
  localparam logic [2:0]         MIN_PRESET  = 3'(MIN_NUM);
  localparam logic [SCORE_W-1:0] WIN_LVL     = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         ARM_LAST    = 8'(ARM_TICKS - 1);
  localparam logic [7:0]         SHOW_LAST   = 8'(SHOW_TICKS - 1);

  state_t     cur_state;
  logic [7:0] tick_cnt;
  logic       tick;
  logic       leave;
  logic [2:0] next_num;

  assign state = cur_state;

  // Restarting the prescaler on every transition makes ARM/SHOW exactly N*TICK_DIV cycles long.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (leave),
    .tick (tick)
  );

  // Preset for the next round: one lower, floored at MIN_NUM.
  assign next_num = (cnt_num > MIN_PRESET) ? cnt_num - 3'd1 : MIN_PRESET;

  // Decide whether the current state is exited at the end of this cycle.
  always_comb begin
    leave = 1'b0;
    case (cur_state)
      ST_IDLE:      leave = start_btn;
      ST_ARM:       leave = p1_btn || p2_btn || (tick && tick_cnt == ARM_LAST);
      ST_RUN:       leave = p1_btn || p2_btn || (cnt_val == 3'd0);
      ST_SHOW:      leave = tick && tick_cnt == SHOW_LAST;
      ST_MATCH_END: leave = start_btn;
      default:      leave = 1'b1;
    endcase
  end

  // Game FSM: state, round arbitration, scoring and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state  <= ST_IDLE;
      cnt_st     <= 1'b0;
      cnt_num    <= INIT_PRESET;
      score1     <= '0;
      score2     <= '0;
      winner     <= WIN_NONE;
      round_done <= 1'b0;
      match_over <= 1'b0;
      tick_cnt   <= '0;
    end else begin
      round_done <= 1'b0;

      if (leave) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= tick_cnt + 8'd1;
      end

      case (cur_state)
        ST_IDLE: begin
          if (leave) cur_state <= ST_ARM;
        end

        ST_ARM: begin
          if (leave) begin
            if (p1_btn || p2_btn) begin
              // Pressing before release is a foul: the opponent scores.
              cur_state  <= ST_SHOW;
              round_done <= 1'b1;
              if (p1_btn && p2_btn) begin
                winner <= WIN_TIE;
              end else if (p1_btn) begin
                winner <= WIN_P2;
                score2 <= sat_inc(score2);
              end else begin
                winner <= WIN_P1;
                score1 <= sat_inc(score1);
              end
            end else begin
              cur_state <= ST_RUN;
              cnt_st    <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (leave) begin
            // A press wins over a simultaneous count-zero timeout.
            cur_state  <= ST_SHOW;
            cnt_st     <= 1'b0;
            round_done <= 1'b1;
            if (p1_btn && p2_btn) begin
              winner <= WIN_TIE;
            end else if (p1_btn) begin
              winner <= WIN_P1;
              score1 <= sat_inc(score1);
            end else if (p2_btn) begin
              winner <= WIN_P2;
              score2 <= sat_inc(score2);
            end else begin
              winner <= WIN_NONE;
            end
          end
        end

        ST_SHOW: begin
          if (leave) begin
            if (score1 >= WIN_LVL || score2 >= WIN_LVL) begin
              cur_state  <= ST_MATCH_END;
              match_over <= 1'b1;
            end else begin
              cur_state <= ST_ARM;
              cnt_num   <= next_num;
            end
          end
        end

        ST_MATCH_END: begin
          if (leave) begin
            cur_state  <= ST_ARM;
            match_over <= 1'b0;
            score1     <= '0;
            score2     <= '0;
            winner     <= WIN_NONE;
            cnt_num    <= INIT_PRESET;
          end
        end

        default: begin
          cur_state  <= ST_IDLE;
          cnt_st     <= 1'b0;
          match_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_game_ctrl.sv
// Round-level reference model of the game driven with randomized rounds.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A small countdown-counter model supplies cnt_val from cnt_st/cnt_num.
module tb_count_game_ctrl;

  localparam int TD     = 4;
  localparam int ARM_T  = 2;
  localparam int SHOW_T = 3;
  localparam int INIT   = 5;
  localparam int MINN   = 1;
  localparam int WINS   = 5;

  localparam logic [2:0] S_IDLE = 3'd0, S_ARM = 3'd1, S_RUN = 3'd2, S_SHOW = 3'd3, S_END = 3'd4;
  localparam int W_NONE = 0, W_P1 = 1, W_P2 = 2, W_TIE = 3;

  localparam int K_FOUL1 = 0, K_FOUL2 = 1, K_FOULT = 2, K_RUN1 = 3, K_RUN2 = 4,
                 K_RUNT = 5, K_TIMEOUT = 6, K_ZERO1 = 7, K_ZERO2 = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn, p1_btn, p2_btn;
  logic [2:0] cnt_val, cnt_num, state;
  logic       cnt_st, round_done, match_over;
  logic [3:0] score1, score2;
  logic [1:0] winner;

  always #5 clk = ~clk;

  count_game_ctrl #(
    .TICK_DIV(TD), .ARM_TICKS(ARM_T), .SHOW_TICKS(SHOW_T),
    .INIT_NUM(INIT), .MIN_NUM(MINN), .WIN_SCORE(WINS)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .p1_btn(p1_btn), .p2_btn(p2_btn),
    .cnt_val(cnt_val), .cnt_num(cnt_num), .cnt_st(cnt_st), .score1(score1), .score2(score2),
    .winner(winner), .round_done(round_done), .match_over(match_over), .state(state)
  );

  // Countdown counter: holds the preset while stopped, steps down once per tick while running.
  int         cdiv;
  logic [2:0] cval;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cval <= 3'(INIT);
      cdiv <= 0;
    end else if (!cnt_st) begin
      cval <= cnt_num;
      cdiv <= 0;
    end else if (cdiv == TD - 1) begin
      cdiv <= 0;
      if (cval != 3'd0) cval <= cval - 3'd1;
    end else begin
      cdiv <= cdiv + 1;
    end
  end
  assign cnt_val = cval;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;

  always @(negedge clk) if (round_done === 1'b1) rd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state: scores and the preset expected for the coming round.
  int m_s1, m_s2, m_num;

  function automatic int inc15(input int v);
    return (v < 15) ? v + 1 : 15;
  endfunction

  task automatic clear_btns();
    start_btn = 1'b0;
    p1_btn    = 1'b0;
    p2_btn    = 1'b0;
  endtask

  task automatic do_start();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
  endtask

  task automatic model_reset();
    m_s1  = 0;
    m_s2  = 0;
    m_num = INIT;
  endtask

  // Play one round starting at the first sampled cycle of ARM.
  task automatic play_round(input int kind, input int t);
    int c, r, n, rd0, win_exp;
    bit arm_st, pressed, foul;
    foul = (kind <= K_FOULT);
    check("arm_entry_state", state, S_ARM);
    check("arm_cnt_num", cnt_num, m_num);
    rd0 = rd_cnt;
    arm_st = 1'b0;
    c = 0;
    while (state == S_ARM && c < 50) begin
      if (cnt_st) arm_st = 1'b1;
      if (foul && c == t) begin
        p1_btn = (kind != K_FOUL2);
        p2_btn = (kind != K_FOUL1);
      end
      if (!foul && c == 1) start_btn = 1'b1;
      @(negedge clk);
      clear_btns();
      c++;
    end
    check("arm_cnt_st_low", arm_st, 0);
    if (foul) begin
      check("foul_len", c, t + 1);
      win_exp = (kind == K_FOUL1) ? W_P2 : (kind == K_FOUL2) ? W_P1 : W_TIE;
    end else begin
      check("arm_len", c, ARM_T * TD);
      check("run_state", state, S_RUN);
      check("run_cnt_st", cnt_st, 1);
      check("run_cnt_num", cnt_num, m_num);
      r = 0;
      pressed = 1'b0;
      while (state == S_RUN && r < 200) begin
        if (!pressed) begin
          if ((kind == K_RUN1 || kind == K_RUN2 || kind == K_RUNT) && cnt_val == 3'(t)) pressed = 1'b1;
          if ((kind == K_ZERO1 || kind == K_ZERO2) && cnt_val == 3'd0) pressed = 1'b1;
          if (pressed) begin
            p1_btn = (kind == K_RUN1 || kind == K_RUNT || kind == K_ZERO1);
            p2_btn = (kind == K_RUN2 || kind == K_RUNT || kind == K_ZERO2);
          end
        end
        @(negedge clk);
        clear_btns();
        r++;
      end
      case (kind)
        K_RUN1, K_ZERO1: win_exp = W_P1;
        K_RUN2, K_ZERO2: win_exp = W_P2;
        K_RUNT:          win_exp = W_TIE;
        default:         win_exp = W_NONE;
      endcase
    end
    if (win_exp == W_P1) m_s1 = inc15(m_s1);
    if (win_exp == W_P2) m_s2 = inc15(m_s2);

    check("show_state", state, S_SHOW);
    check("show_round_done", round_done, 1);
    check("show_cnt_st", cnt_st, 0);
    check("winner", winner, win_exp);
    check("score1", score1, m_s1);
    check("score2", score2, m_s2);

    n = 0;
    while (state == S_SHOW && n < 200) begin
      if (n == 2) begin
        p1_btn = 1'b1;
        p2_btn = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      clear_btns();
      n++;
    end
    check("show_len", n, SHOW_T * TD);
    check("round_done_pulses", rd_cnt - rd0, 1);
    check("show_ignore_s1", score1, m_s1);
    check("show_ignore_s2", score2, m_s2);

    if (m_s1 >= WINS || m_s2 >= WINS) begin
      check("match_end_state", state, S_END);
      check("match_over_hi", match_over, 1);
    end else begin
      m_num = (m_num - 1 > MINN) ? m_num - 1 : MINN;
      check("next_arm_state", state, S_ARM);
      check("next_cnt_num", cnt_num, m_num);
      check("match_over_lo", match_over, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state, S_IDLE);
    check({tag, "_cnt_st"}, cnt_st, 0);
    check({tag, "_cnt_num"}, cnt_num, INIT);
    check({tag, "_score1"}, score1, 0);
    check({tag, "_score2"}, score2, 0);
    check({tag, "_winner"}, winner, W_NONE);
    check({tag, "_round_done"}, round_done, 0);
    check({tag, "_match_over"}, match_over, 0);
  endtask

  initial begin
    int k, t, w;
    rst = 1'b1;
    clear_btns();
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Player buttons do nothing while idle.
    p1_btn = 1'b1;
    @(negedge clk);
    clear_btns();
    check("idle_ignore_state", state, S_IDLE);
    check("idle_ignore_score", score1, 0);

    do_start();

    // Directed rounds: normal win, foul, tie, timeout, press at zero.
    play_round(K_RUN1, 3);
    play_round(K_FOUL2, 3);
    play_round(K_RUNT, $urandom_range(1, m_num));
    play_round(K_TIMEOUT, 0);
    play_round(K_ZERO2, 0);

    // Random rounds until someone reaches the winning score.
    for (int i = 0; i < 40 && state != S_END; i++) begin
      k = $urandom_range(0, 8);
      t = (k <= K_FOULT) ? $urandom_range(0, ARM_T * TD - 1) : $urandom_range(1, m_num);
      play_round(k, t);
    end
    check("random_match_end", state, S_END);

    // MATCH_END holds and ignores player buttons.
    for (int i = 0; i < 5; i++) begin
      p1_btn = 1'b1;
      @(negedge clk);
      clear_btns();
    end
    check("end_hold_state", state, S_END);
    check("end_hold_over", match_over, 1);
    check("end_ignore_s1", score1, m_s1);

    do_start();
    model_reset();
    check("restart_state", state, S_ARM);
    check("restart_score1", score1, 0);
    check("restart_score2", score2, 0);
    check("restart_winner", winner, W_NONE);
    check("restart_cnt_num", cnt_num, INIT);
    check("restart_over", match_over, 0);

    // Player 1 takes five straight rounds; preset walks 5,4,3,2,1.
    for (int i = 0; i < 5; i++) begin
      check("seq_cnt_num", cnt_num, INIT - i);
      play_round(K_RUN1, 1);
    end
    check("p1_match_over", match_over, 1);
    check("p1_final_score", score1, 5);

    // Two wins for player 1, then reset in the middle of the third RUN.
    do_start();
    model_reset();
    play_round(K_RUN1, 2);
    play_round(K_RUN1, 2);
    check("pre_rst_score1", score1, 2);
    w = 0;
    while (state != S_RUN && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("pre_rst_in_run", state, S_RUN);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", state, S_IDLE);

    // A fresh match after reset behaves from the initial preset.
    model_reset();
    do_start();
    play_round(K_RUN2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
